// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two captured WIDTH-bit operands LSB first,
// one full-adder slice per clock, built from two half adders.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic             carry_q;

  logic ha0_s, ha0_c, ha1_c;
  logic slice_s, slice_c;

  // One full-adder slice on the current LSBs of the operand shift registers
  half_adder u_ha0 (
    .x (a_q[0]),
    .y (b_q[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  half_adder u_ha1 (
    .x (ha0_s),
    .y (carry_q),
    .s (slice_s),
    .c (ha1_c)
  );

  assign slice_c = ha0_c | ha1_c;

  // Control and datapath; counter stops at the last bit so it never overruns
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      carry_q   <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            cnt       <= '0;
            carry_q   <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          sum[cnt] <= slice_s;
          carry_q  <= slice_c;
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          if (cnt == LAST_BIT) begin
            carry_out <= slice_c;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
